// File: rtl/ttt_board_evaluator.sv
// Purpose: snapshot the tic-tac-toe board and scan the 8 winning lines, reporting win/draw/illegal.
// Latency: start accepted at edge E, busy during cycles E+1..E+8, done pulse in cycle E+9.
// Backpressure: none; start is only sampled in IDLE and is dropped (not queued) while busy or in DONE.
module ttt_board_evaluator #(
    parameter int STRICT_CHECK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] x_cells,
    input  logic [8:0] o_cells,
    output logic       busy,
    output logic       done,
    output logic       x_win,
    output logic       o_win,
    output logic       draw,
    output logic       err,
    output logic [2:0] win_line
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [8:0] snap_x;
    logic [8:0] snap_o;
    logic [2:0] line_idx;
    logic       x_hit;
    logic       o_hit;

    logic [8:0] line_mask;
    logic       line_x;
    logic       line_o;
    logic       x_hit_nxt;
    logic       o_hit_nxt;
    logic       err_nxt;
    logic       draw_nxt;

    // Cell mask of the line currently being scanned (rows, columns, then the two diagonals).
    always_comb begin
        line_mask = 9'h000;
        case (line_idx)
            3'd0:    line_mask = 9'h007;
            3'd1:    line_mask = 9'h038;
            3'd2:    line_mask = 9'h1C0;
            3'd3:    line_mask = 9'h049;
            3'd4:    line_mask = 9'h092;
            3'd5:    line_mask = 9'h124;
            3'd6:    line_mask = 9'h111;
            default: line_mask = 9'h054;
        endcase
    end

    // Per-line hit detection and the results that land when the last line has been scanned.
    always_comb begin
        line_x    = (snap_x & line_mask) == line_mask;
        line_o    = (snap_o & line_mask) == line_mask;
        x_hit_nxt = x_hit | line_x;
        o_hit_nxt = o_hit | line_o;
        err_nxt   = (STRICT_CHECK != 0) && ((|(snap_x & snap_o)) || (x_hit_nxt && o_hit_nxt));
        draw_nxt  = !x_hit_nxt && !o_hit_nxt && !err_nxt && ((snap_x | snap_o) == 9'h1FF);
    end

    // Control FSM with snapshot, line scan and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            snap_x   <= 9'h000;
            snap_o   <= 9'h000;
            line_idx <= 3'd0;
            x_hit    <= 1'b0;
            o_hit    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            x_win    <= 1'b0;
            o_win    <= 1'b0;
            draw     <= 1'b0;
            err      <= 1'b0;
            win_line <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap_x   <= x_cells;
                        snap_o   <= o_cells;
                        line_idx <= 3'd0;
                        x_hit    <= 1'b0;
                        o_hit    <= 1'b0;
                        x_win    <= 1'b0;
                        o_win    <= 1'b0;
                        draw     <= 1'b0;
                        err      <= 1'b0;
                        win_line <= 3'd0;
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    x_hit <= x_hit_nxt;
                    o_hit <= o_hit_nxt;
                    // Only the first line that hits (either player) is reported.
                    if ((line_x || line_o) && !(x_hit || o_hit)) begin
                        win_line <= line_idx;
                    end
                    if (line_idx == 3'd7) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        x_win <= x_hit_nxt;
                        o_win <= o_hit_nxt;
                        err   <= err_nxt;
                        draw  <= draw_nxt;
                        state <= DONE;
                    end else begin
                        line_idx <= line_idx + 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ttt_board_evaluator.sv
// Scoreboard bench for ttt_board_evaluator: stimulus pushes predicted results, a monitor checks each done pulse.
module tb_ttt_board_evaluator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [8:0] x_cells = 9'h000;
    logic [8:0] o_cells = 9'h000;
    logic       busy, done, x_win, o_win, draw, err;
    logic [2:0] win_line;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int busy_run = 0;

    typedef struct {
        logic [8:0] x;
        logic [8:0] o;
        int         due;
        logic       xw;
        logic       ow;
        logic       dr;
        logic       er;
        logic [2:0] wl;
    } exp_t;

    exp_t sb[$];

    ttt_board_evaluator #(.STRICT_CHECK(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x_cells  (x_cells),
        .o_cells  (o_cells),
        .busy     (busy),
        .done     (done),
        .x_win    (x_win),
        .o_win    (o_win),
        .draw     (draw),
        .err      (err),
        .win_line (win_line)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference: the 8 lines are the 3 rows, 3 columns and 2 diagonals of a 3x3 grid.
    function automatic int cell_of(input int l, input int k);
        if (l < 3)       return l * 3 + k;
        else if (l < 6)  return (l - 3) + 3 * k;
        else if (l == 6) return 4 * k;
        else             return 2 + 2 * k;
    endfunction

    function automatic exp_t model(input logic [8:0] x, input logic [8:0] o, input int due);
        exp_t e;
        bit found = 0;
        e.x = x; e.o = o; e.due = due;
        e.xw = 0; e.ow = 0; e.wl = 3'd0;
        for (int l = 0; l < 8; l++) begin
            bit xl = 1, ol = 1;
            for (int k = 0; k < 3; k++) begin
                if (!x[cell_of(l, k)]) xl = 0;
                if (!o[cell_of(l, k)]) ol = 0;
            end
            if ((xl || ol) && !found) begin
                found = 1;
                e.wl = 3'(l);
            end
            if (xl) e.xw = 1;
            if (ol) e.ow = 1;
        end
        e.er = ((x & o) != 9'h000) || (e.xw && e.ow);
        e.dr = !e.xw && !e.ow && !e.er && ((x | o) == 9'h1FF);
        return e;
    endfunction

    // Caller sits at a negedge; accept happens at the next posedge, next call may accept 10 edges later.
    task automatic run_eval(input logic [8:0] x, input logic [8:0] o, input bit scramble, input bit poke);
        x_cells = x;
        o_cells = o;
        start   = 1'b1;
        sb.push_back(model(x, o, cyc + 9));
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            if (scramble) begin
                x_cells = 9'($urandom);
                o_cells = 9'($urandom);
            end
            start = poke && (i == 3 || i == 8);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Monitor: count busy cycles and compare every done pulse against the oldest prediction.
    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_latency", cyc, e.due);
                    check("busy_cycles", busy_run, 8);
                    check("busy_in_done", int'(busy), 0);
                    check("x_win", int'(x_win), int'(e.xw));
                    check("o_win", int'(o_win), int'(e.ow));
                    check("draw", int'(draw), int'(e.dr));
                    check("err", int'(err), int'(e.er));
                    check("win_line", int'(win_line), int'(e.wl));
                end
                busy_run = 0;
            end
        end
    end

    initial begin
        logic [8:0] rx, ro;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_x_win", int'(x_win), 0);
        check("rst_o_win", int'(o_win), 0);
        check("rst_draw", int'(draw), 0);
        check("rst_err", int'(err), 0);
        check("rst_win_line", int'(win_line), 0);
        rst = 1'b0;
        @(negedge clk);

        run_eval(9'h007, 9'h030, 0, 0);
        run_eval(9'h111, 9'h00A, 0, 0);
        run_eval(9'h0CD, 9'h132, 0, 0);
        run_eval(9'h007, 9'h1C0, 0, 0);
        run_eval(9'h001, 9'h001, 0, 0);
        run_eval(9'h000, 9'h000, 0, 0);
        run_eval(9'h054, 9'h1AB, 1, 1);
        run_eval(9'h1C0, 9'h024, 1, 1);

        // Abort a scan with reset: line 1 already captured, then everything must clear.
        x_cells = 9'h038;
        o_cells = 9'h000;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before", int'(busy), 1);
        check("abort_win_line_before", int'(win_line), 1);
        rst = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_win_line", int'(win_line), 0);
        check("abort_x_win", int'(x_win), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        run_eval(9'h038, 9'h003, 0, 0);

        for (int n = 0; n < 40; n++) begin
            rx = 9'($urandom);
            case ($urandom_range(0, 3))
                0:       ro = 9'($urandom) & ~rx;
                1:       ro = ~rx;
                2:       ro = 9'($urandom);
                default: ro = 9'h000;
            endcase
            run_eval(rx, ro, 1'($urandom), 1'($urandom));
        end

        repeat (15) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
